// File: rtl/leitor_amostras_spi_pkg.sv
// Shared constants and state encoding for the SPI flash sample reader.
// Flash address is {track, word address}; no arithmetic is ever applied to it.
package leitor_amostras_spi_pkg;

  localparam logic [7:0] CMD_READ         = 8'h03;
  localparam int         BITS_QUADRO      = 40;
  localparam int         BIT_INICIO_DADO  = 32;
  localparam logic [7:0] AMOSTRA_SILENCIO = 8'h80;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    QUADRO = 2'd1,
    FIM    = 2'd2
  } estado_t;

endpackage

// File: rtl/leitor_amostras_spi_if.sv
// Request/response bundle between the address state machine (master)
// and the flash sample reader (slave).
interface leitor_amostras_spi_if;

  logic        req;
  logic [21:0] endereco;
  logic [1:0]  musica;
  logic        busy;
  logic [7:0]  amostra;
  logic        amostra_valida;
  logic        erro_overrun;

  modport master (
    output req, endereco, musica,
    input  busy, amostra, amostra_valida, erro_overrun
  );

  modport slave (
    input  req, endereco, musica,
    output busy, amostra, amostra_valida, erro_overrun
  );

endinterface

// File: rtl/leitor_amostras_spi_gerador_sck.sv
// SCK half-period generator: each bit slot is HALF_SCK cycles low then HALF_SCK high.
// Held cleared (SCK low, counter zero) whenever the frame is not active.
module gerador_sck #(
  parameter int HALF_SCK = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ativo,
  output logic sck,
  output logic fim_bit
);

  localparam int             W         = $clog2(2*HALF_SCK + 1);
  localparam logic [W-1:0]   ULT_BAIXO = W'(HALF_SCK - 1);
  localparam logic [W-1:0]   ULT_ALTO  = W'(2*HALF_SCK - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sck_q, sck_d;
  logic         fim_meio;

  always_comb begin
    fim_meio = ativo && (cnt_q == ULT_BAIXO);
    fim_bit  = ativo && (cnt_q == ULT_ALTO);
    cnt_d    = '0;
    sck_d    = 1'b0;
    if (ativo) begin
      cnt_d = fim_bit ? '0 : cnt_q + 1'b1;
      sck_d = fim_meio ? 1'b1 : (fim_bit ? 1'b0 : sck_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck = sck_q;

endmodule

// File: rtl/leitor_amostras_spi.sv
// Reads one 8-bit sample from SPI flash (READ 0x03, mode 0) per accepted request
// and presents it with a one-cycle valid strobe. All outputs come straight from flops.
module leitor_amostras_spi
  import leitor_amostras_spi_pkg::*;
#(
  parameter int HALF_SCK = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  leitor_amostras_spi_if.slave bus,
  output logic                 spi_cs_n,
  output logic                 spi_sck,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  estado_t     estado_q, estado_d;
  logic [39:0] quadro_q, quadro_d;
  logic [5:0]  bit_q, bit_d;
  logic [6:0]  dado_q, dado_d;
  logic [7:0]  amostra_q, amostra_d;
  logic        valida_q, valida_d;
  logic        busy_q, busy_d;
  logic        erro_q, erro_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic        ativo, fim_bit;

  assign ativo = (estado_q == QUADRO);

  gerador_sck #(.HALF_SCK(HALF_SCK)) u_sck (
    .clk     (clk),
    .reset   (reset),
    .ativo   (ativo),
    .sck     (spi_sck),
    .fim_bit (fim_bit)
  );

  always_comb begin
    estado_d  = estado_q;
    quadro_d  = quadro_q;
    bit_d     = bit_q;
    dado_d    = dado_q;
    amostra_d = amostra_q;
    valida_d  = 1'b0;
    busy_d    = busy_q;
    erro_d    = erro_q | (bus.req & busy_q);
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    case (estado_q)
      OCIOSO: begin
        if (bus.req) begin
          quadro_d = {CMD_READ, bus.musica, bus.endereco, 8'h00};
          bit_d    = '0;
          busy_d   = 1'b1;
          cs_n_d   = 1'b0;
          mosi_d   = CMD_READ[7];
          estado_d = QUADRO;
        end
      end
      QUADRO: begin
        if (fim_bit) begin
          if (bit_q >= 6'(BIT_INICIO_DADO))
            dado_d = {dado_q[5:0], spi_miso};
          // Rotate rather than zero-fill: the wrapped bits never reach MOSI.
          quadro_d = {quadro_q[38:0], quadro_q[39]};
          mosi_d   = quadro_q[38];
          bit_d    = bit_q + 6'd1;
          if (bit_q == 6'(BITS_QUADRO - 1)) begin
            amostra_d = {dado_q, spi_miso};
            valida_d  = 1'b1;
            cs_n_d    = 1'b1;
            mosi_d    = 1'b0;
            estado_d  = FIM;
          end
        end
      end
      FIM: begin
        busy_d   = 1'b0;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      quadro_q  <= '0;
      bit_q     <= '0;
      dado_q    <= '0;
      amostra_q <= AMOSTRA_SILENCIO;
      valida_q  <= 1'b0;
      busy_q    <= 1'b0;
      erro_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      quadro_q  <= quadro_d;
      bit_q     <= bit_d;
      dado_q    <= dado_d;
      amostra_q <= amostra_d;
      valida_q  <= valida_d;
      busy_q    <= busy_d;
      erro_q    <= erro_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.amostra        = amostra_q;
  assign bus.amostra_valida = valida_q;
  assign bus.erro_overrun   = erro_q;
  assign spi_cs_n           = cs_n_q;
  assign spi_mosi           = mosi_q;

endmodule

// File: tb/tb_leitor_amostras_spi.sv
// Bench for leitor_amostras_spi: two instances (HALF_SCK=2 and 1), an SPI flash model
// and a protocol monitor, with table-driven reads plus hand-written corner sequences.
module tb_leitor_amostras_spi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   total = 0;
  int   bad   = 0;

  leitor_amostras_spi_if bus0 ();
  leitor_amostras_spi_if bus1 ();

  wire  [1:0] cs_n_v, sck_v, mosi_v;
  logic [1:0] miso_v = 2'b00;

  leitor_amostras_spi #(.HALF_SCK(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .spi_cs_n(cs_n_v[0]), .spi_sck(sck_v[0]), .spi_mosi(mosi_v[0]), .spi_miso(miso_v[0])
  );

  leitor_amostras_spi #(.HALF_SCK(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .spi_cs_n(cs_n_v[1]), .spi_sck(sck_v[1]), .spi_mosi(mosi_v[1]), .spi_miso(miso_v[1])
  );

  wire [1:0]  busy_v    = {bus1.busy, bus0.busy};
  wire [1:0]  valid_v   = {bus1.amostra_valida, bus0.amostra_valida};
  wire [1:0]  erro_v    = {bus1.erro_overrun, bus0.erro_overrun};
  wire [15:0] amostra_v = {bus1.amostra, bus0.amostra};

  task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    end
  endtask

  // Flash model and protocol monitor, both instances, sampled on the falling clock edge.
  logic [7:0]  mdata [2];
  logic [39:0] rx [2];
  int          n_sck [2];
  logic        prev_sck [2]  = '{1'b0, 1'b0};
  logic        prev_cs [2]   = '{1'b1, 1'b1};
  logic        prev_mosi [2] = '{1'b0, 1'b0};
  bit          aborta [2]    = '{1'b1, 1'b1};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) aborta[i] = 1'b1;
      if (prev_cs[i] && !cs_n_v[i]) begin
        n_sck[i]  = 0;
        rx[i]     = '0;
        aborta[i] = 1'b0;
        miso_v[i] = 1'b0;
      end
      if (!cs_n_v[i] && sck_v[i] && !prev_sck[i]) begin
        n_sck[i]++;
        rx[i] = {rx[i][38:0], mosi_v[i]};
      end
      if (!cs_n_v[i] && !sck_v[i] && prev_sck[i] && n_sck[i] >= 32 && n_sck[i] < 40)
        miso_v[i] = mdata[i][39 - n_sck[i]];
      if (sck_v[i] && prev_sck[i])
        chk($sformatf("mosi_estavel[%0d]", i), mosi_v[i], prev_mosi[i]);
      if (!prev_cs[i] && cs_n_v[i] && !aborta[i])
        chk($sformatf("bordas_sck[%0d]", i), n_sck[i], 40);
      prev_sck[i]  = sck_v[i];
      prev_cs[i]   = cs_n_v[i];
      prev_mosi[i] = mosi_v[i];
    end
  end

  task automatic set_req(input int i, input logic r, input logic [1:0] m, input logic [21:0] e);
    if (i == 0) begin
      bus0.req = r; bus0.musica = m; bus0.endereco = e;
    end else begin
      bus1.req = r; bus1.musica = m; bus1.endereco = e;
    end
  endtask

  task automatic leitura(input int i, input logic [1:0] m, input logic [21:0] e,
                         input logic [7:0] d, input logic [39:0] qexp, input int lat);
    int j, half;
    bit sck_ok, cs_ok;
    half   = (i == 0) ? 2 : 1;
    mdata[i] = d;
    @(posedge clk); #1;
    set_req(i, 1'b1, m, e);
    @(negedge clk);
    @(posedge clk); #1;
    set_req(i, 1'b0, 2'd0, 22'd0);
    j = 0; sck_ok = 1'b1; cs_ok = 1'b1;
    while (j < 400) begin
      @(negedge clk);
      j++;
      if (valid_v[i]) break;
      if (sck_v[i] !== (((j - 1) % (2*half)) >= half)) sck_ok = 1'b0;
      if (cs_n_v[i] !== 1'b0 || busy_v[i] !== 1'b1) cs_ok = 1'b0;
    end
    chk($sformatf("latencia[%0d]", i), j, lat);
    chk($sformatf("forma_sck[%0d]", i), sck_ok, 1'b1);
    chk($sformatf("cs_busy_quadro[%0d]", i), cs_ok, 1'b1);
    chk($sformatf("amostra[%0d]", i), amostra_v[i*8 +: 8], d);
    chk($sformatf("fim_cs_busy[%0d]", i), {cs_n_v[i], busy_v[i]}, 2'b11);
    chk($sformatf("quadro_mosi[%0d]", i), rx[i], qexp);
    @(negedge clk);
    chk($sformatf("pos_fim[%0d]", i), {busy_v[i], valid_v[i]}, 2'b00);
    chk($sformatf("sem_overrun[%0d]", i), erro_v[i], 1'b0);
  endtask

  typedef struct {
    int          inst;
    logic [1:0]  musica;
    logic [21:0] endereco;
    logic [7:0]  dado;
    logic [39:0] quadro;
    int          latencia;
  } vec_t;

  vec_t vt [5];
  int   vpos [3];
  int   nvalid, j;
  bit   viu;

  initial begin
    vt[0] = '{0, 2'd1, 22'h012345, 8'hA7, 40'h0341234500, 161};
    vt[1] = '{0, 2'd3, 22'h3FFFFF, 8'h00, 40'h03FFFFFF00, 161};
    vt[2] = '{1, 2'd2, 22'h000001, 8'h5C, 40'h0380000100, 81};
    vt[3] = '{0, 2'd0, 22'h2AAAAA, 8'h3C, 40'h032AAAAA00, 161};
    vt[4] = '{1, 2'd1, 22'h3FFFFF, 8'h81, 40'h037FFFFF00, 81};
    mdata[0] = 8'h00;
    mdata[1] = 8'h00;
    set_req(0, 1'b0, 2'd0, 22'd0);
    set_req(1, 1'b0, 2'd0, 22'd0);
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset[%0d]", i),
          {busy_v[i], amostra_v[i*8 +: 8], valid_v[i], erro_v[i], cs_n_v[i], sck_v[i], mosi_v[i]},
          {1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});

    for (int k = 0; k < 5; k++)
      leitura(vt[k].inst, vt[k].musica, vt[k].endereco, vt[k].dado, vt[k].quadro, vt[k].latencia);

    // Back-to-back: req held high for three frames.
    mdata[0] = 8'hC4;
    vpos = '{0, 0, 0};
    @(posedge clk); #1;
    set_req(0, 1'b1, 2'd1, 22'h0ABCDE);
    @(negedge clk);
    j = 0; nvalid = 0;
    while (j < 600 && nvalid < 3) begin
      @(negedge clk);
      j++;
      if (j == 5) chk("overrun_1o_quadro", erro_v[0], 1'b1);
      if (valid_v[0]) begin
        vpos[nvalid] = j;
        nvalid++;
      end
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 2'd0, 22'd0);
    chk("b2b_pulsos", nvalid, 3);
    chk("b2b_1a_latencia", vpos[0], 161);
    chk("b2b_periodo_1", vpos[1] - vpos[0], 162);
    chk("b2b_periodo_2", vpos[2] - vpos[1], 162);
    chk("b2b_amostra", bus0.amostra, 8'hC4);
    repeat (3) @(negedge clk);
    chk("b2b_parou", busy_v[0], 1'b0);
    chk("overrun_pegajoso", erro_v[0], 1'b1);

    // Reset in the middle of a frame, at T0+50.
    mdata[0] = 8'h3A;
    @(posedge clk); #1;
    set_req(0, 1'b1, 2'd0, 22'h155555);
    @(negedge clk);
    @(posedge clk); #1;
    set_req(0, 1'b0, 2'd0, 22'd0);
    repeat (49) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_meio", {cs_n_v[0], sck_v[0], busy_v[0], bus0.amostra, valid_v[0], erro_v[0]},
        {1'b1, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0});
    viu = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (valid_v[0] || !cs_n_v[0]) viu = 1'b1;
    end
    chk("reset_sem_pulso", viu, 1'b0);
    leitura(0, 2'd2, 22'h3C0F0F, 8'h96, 40'h03BC0F0F00, 161);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/leitor_amostras_spi.md
# leitor_amostras_spi

Responder side of the playback address interface: on each request it takes the current 22-bit word address plus a 2-bit track select, reads one 8-bit sample from the external SPI flash with a standard READ (0x03) transaction, and presents the sample with a one-cycle valid strobe. It sits between the address state machine (initiator) and the PWM/audio output stage. It runs at the 3 kHz sample rate with ample slack.

## Interface
- `HALF_SCK`, default 2: system clocks per SCK half-period; must be ≥1.
- `clk` in 1: system clock; every register updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: read request, sampled each cycle; accepted only when `busy`=0.
- `endereco` in 22: word address, captured on acceptance.
- `musica` in 2: track select, captured on acceptance; flash address = {`musica`, `endereco`}.
- `busy` out 1: transaction in progress.
- `amostra` out 8: last sample read.
- `amostra_valida` out 1: one-cycle pulse when `amostra` updates.
- `erro_overrun` out 1: sticky; set by any `req` while `busy`=1.
- `spi_cs_n` out 1: flash chip select, active-low.
- `spi_sck` out 1: SPI clock, mode 0 (idles low).
- `spi_mosi` out 1: command/address bits, MSB first.
- `spi_miso` in 1: data from flash.

## Operation
- Reset values: `busy`=0, `amostra`=8'h80 (mid-scale silence), `amostra_valida`=0, `erro_overrun`=0, `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0.
- States: OCIOSO → QUADRO → FIM → OCIOSO.
- OCIOSO: when `req`=1, load a 40-bit shift register with {8'h03, `musica`, `endereco`, 8'h00}, clear the bit counter, go to QUADRO.
- QUADRO: 40 bit slots, numbered 0–39, each 2·`HALF_SCK` cycles long.
  - First half of each slot: SCK low, MOSI = current MSB.
  - Second half: SCK high.
  - On the last high cycle of slots 32–39, shift `spi_miso` into the data register, MSB first. Then shift the command register left by one.
  - After slot 39, go to FIM.
- FIM (one cycle): `spi_cs_n`=1, `amostra` ← data register, `amostra_valida`=1, then go to OCIOSO.
- `req` is ignored while `busy`=1, and it sets `erro_overrun`. Only `reset` clears `erro_overrun`.
- Address arithmetic: none. The flash address is the 24-bit concatenation; 22'h3FFFFF with `musica`=3 gives 24'hFFFFFF and needs no special case.
- Reset mid-frame: return to OCIOSO on the next edge with the reset values above. No valid pulse. `amostra` returns to 8'h80.

## Timing
- Let T0 be the cycle in which `req`=1 is sampled in OCIOSO.
- `busy`=1 and `spi_cs_n`=0 from T0+1 through T0+80·`HALF_SCK`.
- Bit k (0–39), with N = `HALF_SCK`:
  - SCK low for cycles T0+1+2kN … T0+2kN+N.
  - SCK high for cycles T0+2kN+N+1 … T0+2(k+1)N.
- FIM is cycle T0+80·`HALF_SCK`+1: `spi_cs_n`=1, `amostra_valida`=1, `busy`=1.
- Earliest next acceptance is T0+80·`HALF_SCK`+2.
- Latency from `req` to valid is 80·`HALF_SCK`+1 cycles, which is 161 cycles at `HALF_SCK`=2.
- `spi_mosi` changes only while SCK is low, and is stable for the whole high phase.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - `CMD_READ` = 8'h03
  - `BITS_QUADRO` = 40
  - `BIT_INICIO_DADO` = 32
  - `AMOSTRA_SILENCIO` = 8'h80
  - the state encoding
- One natural sub-module, `gerador_sck`: half-period counter that produces the `sck` level, `fim_meio` (end of a low half) and `fim_bit` (end of a high half) strobes. It is cleared whenever the FSM is in OCIOSO.
- FSM, shift registers and bit counter live in the top module.

## Test plan
- Single read, `HALF_SCK`=2, `musica`=1, `endereco`=22'h012345; SPI model returns 8'hA7.
  - MOSI carries 8'h03, then 24'h412345.
  - `amostra_valida` pulses at T0+161 with `amostra`=8'hA7.
  - `busy` goes low at T0+162.
- Back-to-back: `req` held high continuously.
  - Transactions start every 162 cycles.
  - `erro_overrun` becomes 1 during the first frame and stays at 1.
- Boundary address: `musica`=3, `endereco`=22'h3FFFFF.
  - MOSI address bits are all 1s.
  - Model data 8'h00 gives `amostra`=8'h00.
- Reset at cycle T0+50 mid-frame.
  - Next cycle: `spi_cs_n`=1, `spi_sck`=0, `busy`=0, `amostra`=8'h80.
  - No valid pulse.
  - A new `req` then completes normally.
- `HALF_SCK`=1 with the model returning 8'h5C.
  - Latency is 81 cycles.
  - The SCK period is 2 clocks.
  - `amostra`=8'h5C.
- Protocol checker, run throughout all tests:
  - exactly 40 SCK rising edges per `spi_cs_n`-low window;
  - MOSI never changes while SCK is high.
